fft_spi_in: RTL

SPI slave receiver that deserializes N words of MSB bits from an external SPI master into a parallel bus. It is the input counterpart of the FFT result SPI transmitter and feeds sample vectors to the FFT stage. It accepts the transmitter's framing style, where CS is asserted per word and the word index persists across CS frames. When a full vector has arrived, it updates the output bus and pulses data_valid.

---
 rtl/fft_spi_in.sv | 89 ++++++++
 1 files changed

// File: rtl/fft_spi_in.sv
// fft_spi_in: SPI mode-0 slave that deserializes N words of MSB bits (cs per word, word index kept across frames) into data_bus, pulsing data_valid per vector and word_err on aborted words; busy while a vector is partially received
module fft_spi_in #(
    parameter int N   = 32,
    parameter int MSB = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             cs,
    input  logic             clr,
    output logic [N*MSB-1:0] data_bus,
    output logic             data_valid,
    output logic             word_err,
    output logic             busy
);
    localparam int IW = $clog2(N);
    localparam int BW = $clog2(MSB);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t                 state;
    logic                   sclk_s1, sclk_s2, sclk_d, mosi_s1, mosi_s2, cs_s1, cs_s2;
    logic [MSB-2:0]         shift_reg;
    logic [BW-1:0]          bit_cnt;
    logic [IW-1:0]          word_idx;
    logic [(N-1)*MSB-1:0]   buffer;
    logic                   rise;
    logic [MSB-1:0]         w;
    assign rise = sclk_s2 & ~sclk_d;
    assign w    = {shift_reg, mosi_s2};
    assign busy = (word_idx != '0) || (bit_cnt != '0);
    always_ff @(posedge clk) begin
        if (rst) begin
            {sclk_s1, sclk_s2, sclk_d, mosi_s1, mosi_s2} <= '0;
            {cs_s1, cs_s2} <= 2'b11;
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            word_idx   <= '0;
            buffer     <= '0;
            data_bus   <= '0;
            data_valid <= 1'b0;
            word_err   <= 1'b0;
        end else begin
            {sclk_s2, sclk_s1} <= {sclk_s1, sclk};
            {mosi_s2, mosi_s1} <= {mosi_s1, mosi};
            {cs_s2, cs_s1}     <= {cs_s1, cs};
            sclk_d     <= sclk_s2;
            data_valid <= 1'b0;
            word_err   <= 1'b0;
            if (clr) begin
                bit_cnt   <= '0;
                word_idx  <= '0;
                shift_reg <= '0;
                state     <= cs_s2 ? IDLE : SHIFT;
            end else if (state == IDLE) begin
                state <= cs_s2 ? IDLE : SHIFT;
            end else begin
                if (state == COMMIT) word_idx <= '0;
                if (cs_s2) begin
                    state <= IDLE;
                    if (bit_cnt != '0) begin
                        word_err  <= 1'b1;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end else begin
                    state <= SHIFT;
                    if (rise) begin
                        shift_reg <= w[MSB-2:0];
                        if (bit_cnt == BW'(MSB-1)) begin
                            bit_cnt <= '0;
                            // last word goes straight to data_bus with the buffered ones
                            if (word_idx == IW'(N-1)) begin
                                data_bus   <= {w, buffer};
                                data_valid <= 1'b1;
                                state      <= COMMIT;
                            end else begin
                                buffer[word_idx*MSB +: MSB] <= w;
                                word_idx <= word_idx + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule
